// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - control-step sequencer for register-register ALU instructions
// Moore controls decoded from the state register plus the live IR fields.
module alu_op_sequencer #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4,
   parameter int MD_LAT    = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         ir,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [NUM_REGS-1:0] reg_out,
   output logic [NUM_REGS-1:0] reg_in,
   output logic [5:0]          ctl_out,
   output logic [8:0]          ctl_in,
   output logic                inc_pc,
   output logic [12:0]         alu_op
);

   localparam int CW     = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
   localparam int RA_HI  = 26;
   localparam int RB_HI  = 26 - REG_SEL_W;
   localparam int RC_HI  = 26 - 2 * REG_SEL_W;
   localparam int LOW_HI = 26 - 3 * REG_SEL_W;

   localparam int PC_OUT = 5, MDR_OUT = 4, ZLO_OUT = 3, ZHI_OUT = 2;
   localparam int PC_IN = 8, IR_IN = 7, MAR_IN = 6, MDR_IN = 5, Y_IN = 4, Z_IN = 3;
   localparam int HI_IN = 2, LO_IN = 1, READ = 0;
   localparam int OP_AND = 12, OP_OR = 11, OP_ADD = 10, OP_SUB = 9, OP_MUL = 8, OP_DIV = 7;
   localparam int OP_SHR = 6, OP_SHRA = 5, OP_SHL = 4, OP_ROR = 3, OP_ROL = 2, OP_NEG = 1, OP_NOT = 0;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_WAIT, S_T5, S_T6
   } state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [4:0]          opcode;
   logic [REG_SEL_W-1:0] ra, rb, rc;
   logic [12:0]         op_vec;
   logic                cls_3, cls_1, cls_md, legal;
   logic                unused_ir;

   assign opcode    = ir[31:27];
   assign ra        = ir[RA_HI -: REG_SEL_W];
   assign rb        = ir[RB_HI -: REG_SEL_W];
   assign rc        = ir[RC_HI -: REG_SEL_W];
   assign unused_ir = ^ir[LOW_HI:0];

   function automatic logic fld_ok(input logic [REG_SEL_W-1:0] r);
      return int'(r) < NUM_REGS;
   endfunction

   // Out-of-range selects decode to no register rather than aliasing.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] r);
      logic [NUM_REGS-1:0] oh;
      for (int i = 0; i < NUM_REGS; i++) oh[i] = (int'(r) == i);
      return oh;
   endfunction

   always_comb begin
      op_vec = '0;
      cls_3  = 1'b0;
      cls_1  = 1'b0;
      cls_md = 1'b0;
      case (opcode)
         5'b00011: begin op_vec[OP_ADD]  = 1'b1; cls_3  = 1'b1; end
         5'b00100: begin op_vec[OP_SUB]  = 1'b1; cls_3  = 1'b1; end
         5'b00101: begin op_vec[OP_AND]  = 1'b1; cls_3  = 1'b1; end
         5'b00110: begin op_vec[OP_OR]   = 1'b1; cls_3  = 1'b1; end
         5'b00111: begin op_vec[OP_ROR]  = 1'b1; cls_3  = 1'b1; end
         5'b01000: begin op_vec[OP_ROL]  = 1'b1; cls_3  = 1'b1; end
         5'b01001: begin op_vec[OP_SHR]  = 1'b1; cls_3  = 1'b1; end
         5'b01010: begin op_vec[OP_SHRA] = 1'b1; cls_3  = 1'b1; end
         5'b01011: begin op_vec[OP_SHL]  = 1'b1; cls_3  = 1'b1; end
         5'b01111: begin op_vec[OP_DIV]  = 1'b1; cls_md = 1'b1; end
         5'b10000: begin op_vec[OP_MUL]  = 1'b1; cls_md = 1'b1; end
         5'b10001: begin op_vec[OP_NEG]  = 1'b1; cls_1  = 1'b1; end
         5'b10010: begin op_vec[OP_NOT]  = 1'b1; cls_1  = 1'b1; end
         default: ;
      endcase
      legal = (cls_3 && fld_ok(ra) && fld_ok(rb) && fld_ok(rc)) ||
              ((cls_1 || cls_md) && fld_ok(ra) && fld_ok(rb));
   end

   // Final writeback steps go straight to T0 when start is still high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) state <= S_T0;
            S_T0:   state <= S_T1;
            S_T1:   state <= S_T2;
            S_T2:   state <= S_DEC;
            S_DEC:  state <= legal ? S_T3 : S_IDLE;
            S_T3:   state <= S_T4;
            S_T4: begin
               if (cls_1) state <= start ? S_T0 : S_IDLE;
               else if (cls_md && MD_LAT > 0) begin
                  state <= S_WAIT;
                  cnt   <= '0;
               end else state <= S_T5;
            end
            S_WAIT: begin
               if (cnt == CW'(MD_LAT - 1)) state <= S_T5;
               else cnt <= cnt + CW'(1);
            end
            S_T5:   state <= cls_md ? S_T6 : (start ? S_T0 : S_IDLE);
            S_T6:   state <= start ? S_T0 : S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy    = (state != S_IDLE);
      done    = 1'b0;
      err     = 1'b0;
      reg_out = '0;
      reg_in  = '0;
      ctl_out = '0;
      ctl_in  = '0;
      inc_pc  = 1'b0;
      alu_op  = '0;
      case (state)
         S_T0: begin
            ctl_out[PC_OUT] = 1'b1;
            ctl_in[MAR_IN]  = 1'b1;
            ctl_in[Z_IN]    = 1'b1;
            inc_pc          = 1'b1;
         end
         S_T1: begin
            ctl_out[ZLO_OUT] = 1'b1;
            ctl_in[PC_IN]    = 1'b1;
            ctl_in[READ]     = 1'b1;
            ctl_in[MDR_IN]   = 1'b1;
         end
         S_T2: begin
            ctl_out[MDR_OUT] = 1'b1;
            ctl_in[IR_IN]    = 1'b1;
         end
         S_DEC: err = !legal;
         S_T3: begin
            if (cls_1) begin
               reg_out      = onehot(rb);
               alu_op       = op_vec;
               ctl_in[Z_IN] = 1'b1;
            end else begin
               reg_out      = cls_md ? onehot(ra) : onehot(rb);
               ctl_in[Y_IN] = 1'b1;
            end
         end
         S_T4: begin
            if (cls_1) begin
               ctl_out[ZLO_OUT] = 1'b1;
               reg_in           = onehot(ra);
               done             = 1'b1;
            end else begin
               reg_out      = cls_md ? onehot(rb) : onehot(rc);
               alu_op       = op_vec;
               ctl_in[Z_IN] = 1'b1;
            end
         end
         S_WAIT: begin
            alu_op       = op_vec;
            ctl_in[Z_IN] = 1'b1;
         end
         S_T5: begin
            ctl_out[ZLO_OUT] = 1'b1;
            if (cls_md) ctl_in[LO_IN] = 1'b1;
            else begin
               reg_in = onehot(ra);
               done   = 1'b1;
            end
         end
         S_T6: begin
            ctl_out[ZHI_OUT] = 1'b1;
            ctl_in[HI_IN]    = 1'b1;
            done             = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer
// Instance a: defaults with a small datapath model; instance b: NUM_REGS=8, MD_LAT=2.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [31:0] ir_a = '0, ir_b = '0;

   logic        busy_a, done_a, err_a, inc_pc_a;
   logic [15:0] reg_out_a, reg_in_a;
   logic [5:0]  ctl_out_a;
   logic [8:0]  ctl_in_a;
   logic [12:0] alu_op_a;

   logic        busy_b, done_b, err_b, inc_pc_b;
   logic [7:0]  reg_out_b, reg_in_b;
   logic [5:0]  ctl_out_b;
   logic [8:0]  ctl_in_b;
   logic [12:0] alu_op_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs [16];
   logic [31:0] y_reg, bus;
   logic [63:0] z_reg;
   logic        reg_seen_a = 1'b0, reg_seen_b = 1'b0, yin_seen_a = 1'b0;

   always #5 clk = ~clk;

   alu_op_sequencer dut_a (
      .clk(clk), .reset(reset), .start(start_a), .ir(ir_a),
      .busy(busy_a), .done(done_a), .err(err_a),
      .reg_out(reg_out_a), .reg_in(reg_in_a),
      .ctl_out(ctl_out_a), .ctl_in(ctl_in_a),
      .inc_pc(inc_pc_a), .alu_op(alu_op_a)
   );

   alu_op_sequencer #(.NUM_REGS(8), .REG_SEL_W(4), .MD_LAT(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .ir(ir_b),
      .busy(busy_b), .done(done_b), .err(err_b),
      .reg_out(reg_out_b), .reg_in(reg_in_b),
      .ctl_out(ctl_out_b), .ctl_in(ctl_in_b),
      .inc_pc(inc_pc_b), .alu_op(alu_op_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Single-bus datapath for instance a (only the ops exercised here).
   always_comb begin
      bus = '0;
      for (int i = 0; i < 16; i++) if (reg_out_a[i]) bus = regs[i];
      if (ctl_out_a[3]) bus = z_reg[31:0];
      if (ctl_out_a[2]) bus = z_reg[63:32];
   end

   always @(posedge clk) begin
      if (ctl_in_a[4]) y_reg <= bus;
      if (ctl_in_a[3]) begin
         case (alu_op_a)
            13'h1000: z_reg <= {32'h0, y_reg & bus};
            13'h0400: z_reg <= {32'h0, y_reg + bus};
            13'h0001: z_reg <= {32'h0, ~bus};
            default:  z_reg <= 64'h0;
         endcase
      end
      for (int i = 0; i < 16; i++) if (reg_in_a[i]) regs[i] <= bus;
   end

   always @(negedge clk) begin
      chk("bus_drivers", 32'(($countones({reg_out_a, ctl_out_a}) <= 1) &&
                             ($countones({reg_out_b, ctl_out_b}) <= 1)), 32'd1);
      if (reg_in_a != 0) reg_seen_a = 1'b1;
      if (reg_in_b != 0) reg_seen_b = 1'b1;
      if (ctl_in_a[4]) yin_seen_a = 1'b1;
   end

   task automatic fetch_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      chk("a_T0", {ctl_out_a, ctl_in_a, inc_pc_a, busy_a}, {6'b100000, 9'b001001000, 1'b1, 1'b1});
      tick();
      chk("a_T1", {ctl_out_a, ctl_in_a, inc_pc_a}, {6'b001000, 9'b100100001, 1'b0});
      tick();
      chk("a_T2", {ctl_out_a, ctl_in_a}, {6'b010000, 9'b010000000});
      tick();
      chk("a_DEC", {ctl_out_a, ctl_in_a, reg_out_a, alu_op_a, busy_a}, {6'b0, 9'b0, 16'h0, 13'h0, 1'b1});
   endtask

   initial begin
      int dc[3];
      int n;
      for (int i = 0; i < 16; i++) regs[i] = '0;
      y_reg = '0;
      z_reg = '0;

      // reset state
      tick();
      chk("rst_flags", {busy_a, done_a, err_a, inc_pc_a, busy_b}, 5'b0);
      chk("rst_regs", {reg_out_a, reg_in_a}, 32'h0);
      chk("rst_ctl", {ctl_out_a, ctl_in_a, alu_op_a}, 28'h0);
      reset = 1'b1;
      tick();
      chk("idle_busy", {busy_a, busy_b}, 2'b00);

      // reset asserted in T4 of an AND
      regs[3] = 32'h22;
      regs[7] = 32'h24;
      ir_a = 32'h2A1B8000;
      fetch_a();
      tick();
      tick();
      chk("rstmid_T4", alu_op_a, 13'h1000);
      reset = 1'b0;
      #1;
      chk("rstmid_now", {busy_a, done_a, ctl_out_a, ctl_in_a, alu_op_a, reg_out_a}, 32'h0);
      tick();
      chk("rstmid_next", {busy_a, reg_in_a}, 17'h0);
      reset = 1'b1;
      chk("rstmid_nowb", {reg_seen_a, regs[4]}, 33'h0);

      // AND R4,R3,R7
      tick();
      fetch_a();
      tick();
      chk("and_T3", {reg_out_a, ctl_in_a, alu_op_a}, {16'h0008, 9'h010, 13'h0});
      tick();
      chk("and_T4", {reg_out_a, ctl_in_a, alu_op_a}, {16'h0080, 9'h008, 13'h1000});
      tick();
      chk("and_T5", {ctl_out_a, reg_in_a, done_a, reg_out_a}, {6'b001000, 16'h0010, 1'b1, 16'h0});
      tick();
      chk("and_idle", {busy_a, done_a}, 2'b00);
      chk("and_R4", regs[4], 32'h20);

      // NOT R5,R2
      regs[2] = 32'h0F0F0F0F;
      ir_a = 32'h92900000;
      yin_seen_a = 1'b0;
      fetch_a();
      tick();
      chk("not_T3", {reg_out_a, ctl_in_a, alu_op_a}, {16'h0004, 9'h008, 13'h0001});
      tick();
      chk("not_T4", {ctl_out_a, reg_in_a, done_a}, {6'b001000, 16'h0020, 1'b1});
      tick();
      chk("not_idle", busy_a, 1'b0);
      chk("not_noY", yin_seen_a, 1'b0);
      chk("not_R5", regs[5], 32'hF0F0F0F0);

      // illegal opcode 00000
      ir_a = 32'h0;
      reg_seen_a = 1'b0;
      fetch_a();
      chk("ill_err", err_a, 1'b1);
      tick();
      chk("ill_idle", {busy_a, err_a, reg_seen_a}, 3'b000);

      // three back-to-back ADD R1,R2,R3
      regs[2] = 32'd5;
      regs[3] = 32'd7;
      regs[1] = 32'd0;
      ir_a = 32'h18918000;
      start_a = 1'b1;
      n = 0;
      for (int c = 1; c <= 40 && n < 3; c++) begin
         tick();
         if (done_a) begin
            dc[n] = c;
            n++;
            if (n == 3) start_a = 1'b0;
         end
      end
      start_a = 1'b0;
      chk("b2b_count", n, 3);
      if (n == 3) begin
         chk("b2b_first", dc[0], 7);
         chk("b2b_gap1", dc[1] - dc[0], 7);
         chk("b2b_gap2", dc[2] - dc[1], 7);
      end
      tick();
      chk("b2b_idle", busy_a, 1'b0);
      chk("b2b_R1", regs[1], 32'd12);

      // MUL R3,R1 on instance b (MD_LAT=2)
      ir_b = 32'h81880000;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      chk("mul_T0", {busy_b, inc_pc_b}, 2'b11);
      tick();
      tick();
      tick();
      chk("mul_DEC", {err_b, busy_b}, 2'b01);
      tick();
      chk("mul_T3", {reg_out_b, ctl_in_b}, {8'h08, 9'h010});
      tick();
      chk("mul_T4", {reg_out_b, ctl_in_b, alu_op_b}, {8'h02, 9'h008, 13'h0100});
      tick();
      chk("mul_W1", {reg_out_b, ctl_out_b, ctl_in_b, alu_op_b}, {8'h00, 6'b0, 9'h008, 13'h0100});
      tick();
      chk("mul_W2", {reg_out_b, ctl_out_b, ctl_in_b, alu_op_b}, {8'h00, 6'b0, 9'h008, 13'h0100});
      tick();
      chk("mul_T5", {ctl_out_b, ctl_in_b, done_b}, {6'b001000, 9'h002, 1'b0});
      tick();
      chk("mul_T6", {ctl_out_b, ctl_in_b, done_b}, {6'b000100, 9'h004, 1'b1});
      tick();
      chk("mul_idle", {busy_b, done_b}, 2'b00);

      // ADD with Ra=8 on an 8-register instance
      ir_b = 32'h1C000000;
      reg_seen_b = 1'b0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      tick();
      tick();
      tick();
      chk("fld_err", err_b, 1'b1);
      tick();
      chk("fld_idle", {busy_b, err_b, reg_seen_b}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
